slow_input_scheduler: RTL and testbench
=======================================

Name: slow_input_scheduler

Overview:
Time-multiplexed scan controller for a bank of slow external inputs such as buttons, switches and strap pins. It synchronizes each input and visits one channel per prescaled sample tick in round-robin order. A shared compare/count datapath debounces the visited channel. Every accepted level change is reported as one event on a valid/ready interface that feeds the capture-control logic, so slow inputs share a single sampling resource.

Parameters:
NUM_IN, 4, number of slow inputs scanned (2..16)
TICK_DIV, 1000, IDLE clocks between channel samples (>=1)
STABLE_CNT, 4, consecutive mismatching visits required to accept a new level (1..255)
CHAN_W, 2, width of channel index, = clog2(NUM_IN)
CNT_W, 3, width of per-channel debounce counter, = clog2(STABLE_CNT+1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
in  in  NUM_IN  raw asynchronous slow inputs
scan_en  in  1  1 = scanning enabled
level  out  NUM_IN  debounced accepted level per channel
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_chan  out  CHAN_W  channel of pending event
evt_level  out  1  new level of pending event

Behaviour:
- Reset (rst=0, async): clears sync flops, level, every debounce counter, the channel pointer, the prescaler, evt_valid, evt_chan and evt_level to 0; FSM goes to IDLE. Asserting reset mid-operation drops evt_valid immediately, and any pending event is lost.
- Synchronizer: each in[i] passes through 2 flops, and s[i] is the second-flop output. Only s is used downstream.
- Prescaler: counts only in IDLE with scan_en=1; holds its value otherwise.
  - At count==TICK_DIV-1 it wraps to 0 and the FSM moves to SAMPLE.
  - TICK_DIV=1 gives one SAMPLE per 2 clocks.
- FSM states:
  - IDLE: wait for tick, as above.
  - SAMPLE: exactly 1 cycle, acts on channel p = pointer.
    - If s[p]==level[p], then cnt[p]<=0 and next state is IDLE.
    - Else if cnt[p]+1==STABLE_CNT, then level[p]<=s[p], cnt[p]<=0, evt_chan<=p, evt_level<=s[p], evt_valid<=1, and next state is EMIT.
    - Else cnt[p]<=cnt[p]+1 and next state is IDLE.
    - The pointer advances to (p+1) mod NUM_IN in every SAMPLE; wrap from NUM_IN-1 to 0 is required for non-power-of-2 NUM_IN.
  - EMIT: evt_valid, evt_chan and evt_level are held stable until evt_valid&&evt_ready. On that cycle evt_valid<=0 and next state is IDLE. The prescaler is frozen, so scanning stalls while the consumer backpressures. Events are never dropped or overwritten.
- evt_ready is ignored when evt_valid=0. A ready held high accepts an event on the first EMIT cycle, giving a 1-cycle evt_valid pulse.
- scan_en=0: FSM stays in IDLE and prescaler, pointer and counters hold. An EMIT already in progress completes normally, and an in-progress SAMPLE completes its single cycle.
- level updates registered in the SAMPLE cycle. evt_valid rises in the same edge as level[p].
- Per-channel revisit period without events: NUM_IN*(TICK_DIV+1) clocks.
- Worst-case acceptance latency from an input edge: 2 sync clocks + STABLE_CNT revisit periods.
- Counter never exceeds STABLE_CNT-1 when stored. Any single matching visit clears it, which rejects glitches shorter than one revisit period.
- Inputs high at reset: level reads 0, then a rise event is produced after debounce. This is intentional, because downstream consumers get initial states as events.

Test Plan:
All scenarios use NUM_IN=4, TICK_DIV=4, STABLE_CNT=3, evt_ready=1 and revisit period 20 clocks unless stated.
- Reset/idle: rst=0 for 2 cycles with in=0, then release and run 200 cycles -> level=0, evt_valid never asserted, pointer cycles 0,1,2,3,0.
- Rise accept: in[2]=1 held -> exactly one evt_valid pulse with evt_chan=2 and evt_level=1, within 2+3*20+5 clocks. level[2]=1 in the same cycle, and no further events.
- Glitch reject: in[1]=1 for 10 clocks then 0 -> no event, level[1] stays 0, cnt[1] returns to 0.
- Backpressure: evt_ready=0, in[0] and in[3] both rise -> evt_valid=1 with evt_chan=0 and evt_level=1 held stable, no SAMPLE occurs, prescaler frozen. Raise evt_ready for 1 cycle -> chan 0 event accepted, then a chan 3 event follows. Exactly 2 events total.
- Fall and scan_en: after level[2]=1, set in[2]=0 and hold scan_en=0 for 100 clocks -> no event, counters frozen. Then scan_en=1 -> fall event with evt_chan=2 and evt_level=0.
- Async reset mid-EMIT: assert rst while evt_valid=1 and evt_ready=0 -> evt_valid and level drop to 0 asynchronously, before the next clk edge. After release with inputs still high, rise events are re-reported.

Source files
------------

// File: rtl/slow_input_scheduler.sv
// Round-robin debounce scanner for a bank of slow external inputs.
// One shared compare/count path; accepted level changes leave as valid/ready events.
module slow_input_scheduler #(
  parameter int NUM_IN     = 4,
  parameter int TICK_DIV   = 1000,
  parameter int STABLE_CNT = 4,
  parameter int CHAN_W     = $clog2(NUM_IN),
  parameter int CNT_W      = $clog2(STABLE_CNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] in,
  input  logic              scan_en,
  output logic [NUM_IN-1:0] level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CHAN_W-1:0] evt_chan,
  output logic              evt_level
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_TOP = PRE_W'(TICK_DIV - 1);
  localparam logic [CHAN_W-1:0] PTR_TOP = CHAN_W'(NUM_IN - 1);
  localparam logic [CNT_W:0]    CNT_TOP = (CNT_W + 1)'(STABLE_CNT);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    EMIT
  } state_t;

  state_t            state;
  logic [NUM_IN-1:0] meta;
  logic [NUM_IN-1:0] s;
  logic [PRE_W-1:0]  pre;
  logic [CHAN_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt [NUM_IN];

  logic              cur;
  logic              hit;
  logic [CNT_W:0]    cnt_inc;

  // Shared datapath: only the visited channel is compared and counted.
  always_comb begin
    cur     = s[ptr];
    hit     = (cur == level[ptr]);
    cnt_inc = {1'b0, cnt[ptr]} + (CNT_W + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      s    <= '0;
    end else begin
      meta <= in;
      s    <= meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pre       <= '0;
      ptr       <= '0;
      level     <= '0;
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      evt_level <= 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (scan_en) begin
            if (pre == PRE_TOP) begin
              pre   <= '0;
              state <= SAMPLE;
            end else begin
              pre <= pre + PRE_W'(1);
            end
          end
        end
        SAMPLE: begin
          ptr   <= (ptr == PTR_TOP) ? '0 : ptr + CHAN_W'(1);
          state <= IDLE;
          if (hit) begin
            cnt[ptr] <= '0;
          end else if (cnt_inc == CNT_TOP) begin
            level[ptr] <= cur;
            cnt[ptr]   <= '0;
            evt_chan   <= ptr;
            evt_level  <= cur;
            evt_valid  <= 1'b1;
            state      <= EMIT;
          end else begin
            cnt[ptr] <= cnt_inc[CNT_W-1:0];
          end
        end
        EMIT: begin
          // Scanning stalls here so no event is ever overwritten.
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slow_input_scheduler.sv
// Bench for slow_input_scheduler: directed scenarios plus random traffic,
// checked every cycle against a scan-schedule reference model.
module tb_slow_input_scheduler;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int SC = 3;
  localparam int CW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  din;
  logic          scan_en;
  logic [N-1:0]  level;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_chan;
  logic          evt_level;

  int n_chk  = 0;
  int n_pass = 0;
  int n_evt  = 0;

  slow_input_scheduler #(
    .NUM_IN(N),
    .TICK_DIV(TD),
    .STABLE_CNT(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(din),
    .scan_en(scan_en),
    .level(level),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_chan(evt_chan),
    .evt_level(evt_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: synced history, a schedule of idle gaps and visits,
  // per-channel mismatch streaks and a single pending event slot.
  bit [N-1:0] hist1, hist2, m_level, m_s;
  int         streak [N];
  int         m_ptr, gap;
  bit         visit_due, m_pend, m_elev;
  int         m_chan;

  task automatic m_reset();
    hist1 = '0; hist2 = '0; m_level = '0;
    for (int i = 0; i < N; i++) streak[i] = 0;
    m_ptr = 0; gap = 0; visit_due = 0;
    m_pend = 0; m_chan = 0; m_elev = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reset();
    end else begin
      m_s = hist2;
      if (m_pend) begin
        if (evt_ready) m_pend = 0;
      end else if (visit_due) begin
        visit_due = 0;
        if (m_s[m_ptr] == m_level[m_ptr]) begin
          streak[m_ptr] = 0;
        end else begin
          streak[m_ptr] = streak[m_ptr] + 1;
          if (streak[m_ptr] == SC) begin
            streak[m_ptr]  = 0;
            m_level[m_ptr] = m_s[m_ptr];
            m_pend = 1; m_chan = m_ptr; m_elev = m_s[m_ptr];
          end
        end
        m_ptr = (m_ptr + 1) % N;
      end else if (scan_en) begin
        if (gap == TD - 1) begin
          gap = 0; visit_due = 1;
        end else begin
          gap = gap + 1;
        end
      end
      hist2 = hist1;
      hist1 = din;
    end
  end

  always @(posedge clk) begin
    if (rst && evt_valid && evt_ready) n_evt <= n_evt + 1;
  end

  always @(negedge clk) begin
    chk("level", int'(level), int'(m_level));
    chk("evt_valid", int'(evt_valid), int'(m_pend));
    if (m_pend) begin
      chk("evt_chan", int'(evt_chan), m_chan);
      chk("evt_level", int'(evt_level), int'(m_elev));
    end
  end

  task automatic wait_evt(input int lim, output bit found);
    found = 0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk);
      if (evt_valid) found = 1;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int e0;
  bit found;

  initial begin
    rst = 1'b0; din = '0; scan_en = 1'b1; evt_ready = 1'b1;
    cycles(2);
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(evt_valid), 0);
    rst = 1'b1;
    cycles(200);
    chk("idle_events", n_evt, 0);
    chk("idle_level", int'(level), 0);

    // Rise on channel 2
    e0 = n_evt;
    din[2] = 1'b1;
    wait_evt(2 + 3 * 20 + 5, found);
    chk("rise_seen", int'(found), 1);
    chk("rise_chan", int'(evt_chan), 2);
    chk("rise_lvl", int'(evt_level), 1);
    chk("rise_level2", int'(level[2]), 1);
    cycles(100);
    chk("rise_count", n_evt - e0, 1);

    // Glitch shorter than a revisit period on channel 1
    e0 = n_evt;
    din[1] = 1'b1;
    cycles(10);
    din[1] = 1'b0;
    cycles(100);
    chk("glitch_count", n_evt - e0, 0);
    chk("glitch_level1", int'(level[1]), 0);

    // Backpressure: align so channel 0 is visited first after the rise
    evt_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m_ptr == 0 && gap == 0 && !visit_due && !m_pend) found = 1;
    end
    chk("bp_align", int'(found), 1);
    e0 = n_evt;
    din[0] = 1'b1;
    din[3] = 1'b1;
    wait_evt(100, found);
    chk("bp_seen", int'(found), 1);
    chk("bp_chan0", int'(evt_chan), 0);
    chk("bp_lvl0", int'(evt_level), 1);
    cycles(50);
    chk("bp_hold_valid", int'(evt_valid), 1);
    chk("bp_hold_chan", int'(evt_chan), 0);
    chk("bp_level3_held", int'(level[3]), 0);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    wait_evt(40, found);
    chk("bp_second_seen", int'(found), 1);
    chk("bp_chan3", int'(evt_chan), 3);
    evt_ready = 1'b1;
    cycles(50);
    chk("bp_count", n_evt - e0, 2);

    // Fall on channel 2 while scanning is paused, then resumed
    e0 = n_evt;
    scan_en = 1'b0;
    din[2] = 1'b0;
    cycles(100);
    chk("pause_count", n_evt - e0, 0);
    chk("pause_level2", int'(level[2]), 1);
    scan_en = 1'b1;
    wait_evt(70, found);
    chk("fall_seen", int'(found), 1);
    chk("fall_chan", int'(evt_chan), 2);
    chk("fall_lvl", int'(evt_level), 0);

    // Async reset while an event is held
    evt_ready = 1'b0;
    din[1] = 1'b1;
    wait_evt(70, found);
    chk("ar_seen", int'(found), 1);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid_drop", int'(evt_valid), 0);
    chk("ar_level_drop", int'(level), 0);
    cycles(2);
    rst = 1'b1;
    evt_ready = 1'b1;
    e0 = n_evt;
    cycles(150);
    chk("ar_rereport", n_evt - e0, 3);
    chk("ar_level", int'(level), 4'b1011);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) din[$urandom_range(0, N - 1)] ^= 1'b1;
      evt_ready = ($urandom_range(0, 3) != 0);
      scan_en   = ($urandom_range(0, 15) != 0);
    end
    evt_ready = 1'b1;
    scan_en = 1'b1;
    cycles(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
